tpose_pp: RTL and testbench
===========================

TPOSE_PP -- requirements
Module: tpose_pp

Interface
REQ-001 Parameter: N, 8, channel count and matrix dimension (N x N); N >= 2.
REQ-002 Parameter: W, 16, data word width in bits.
REQ-003 Port: clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: a_d  input  N*W  input row vector; channel k occupies bits [k*W +: W].
REQ-006 Port: a_e  input  N  per-channel end-of-stream flag, qualified by a_v.
REQ-007 Port: a_v  input  N  per-channel input valid.
REQ-008 Port: a_b  output  N  per-channel back-pressure to the producer; all bits always equal.
REQ-009 Port: b_d  output  N*W  output vector; channel k occupies bits [k*W +: W].
REQ-010 Port: b_e  output  N  per-channel end-of-stream flag; all bits always equal.
REQ-011 Port: b_v  output  N  per-channel output valid; all bits always equal.
REQ-012 Port: b_b  input  N  per-channel back-pressure from the consumer.
REQ-013 Port: mode  input  1  selects transpose (0) or row pass-through (1); sampled when a matrix starts.
REQ-014 Port: err  output  1  sticky flag; set when end-of-stream arrives mid-matrix.

Function
REQ-015 Input fire SHALL be &a_v & ~a_b[0]; output fire SHALL be b_v[0] & ~|b_b.
REQ-016 Input fire with ~&a_e SHALL write row r (r = 0..N-1) of the fill bank: M[r][k] = a_d channel k.
REQ-017 Two banks (ping-pong) SHALL alternate between fill and drain roles; each bank state is EMPTY, FILLING or FULL.
REQ-018 A bank SHALL go EMPTY->FILLING on its first row write and FILLING->FULL on the write of row N-1.
REQ-019 A FULL bank SHALL drain one vector per output fire, column c = 0..N-1; transpose mode: b_d channel k = M[k][c]; pass-through mode: b_d channel k = M[c][k].
REQ-020 The mode used for draining SHALL be the value of mode captured on the row-0 write of that bank.
REQ-021 After the fire of column N-1 the draining bank SHALL go EMPTY, and the drain pointer SHALL move to the other bank.
REQ-022 b_v SHALL be high exactly when the drain bank is FULL, or when an end-of-stream token is ready to emit (REQ-026).
REQ-023 First output latency: b_v SHALL rise the cycle after the row N-1 input fire.
REQ-024 a_b SHALL be high when the fill bank is FULL, or when an end-of-stream token is pending (REQ-026), or during reset.
REQ-025 Sustained throughput SHALL be one matrix per N cycles with a_v all high and b_b all low; there SHALL be no bubbles at bank swaps.
REQ-026 Input fire with &a_e SHALL take an end-of-stream token; a_d is ignored and a_b is held high until the token is emitted.
REQ-027 The token SHALL be emitted after every FULL bank has drained, as one output vector with b_e all 1, b_d = 0 and b_v all 1.
REQ-028 A token taken while the fill bank is FILLING SHALL discard the partial matrix (bank -> EMPTY) and set err.
REQ-029 Mixed a_e values at an input fire SHALL be treated as data with the a_e bits ignored.
REQ-030 Fill completion and drain completion in the same cycle SHALL both take effect, and the two banks SHALL swap roles.
REQ-031 While stalled (b_b nonzero), b_d, b_e and b_v SHALL hold their values.

Reset
REQ-032 Reset SHALL clear both banks to EMPTY, the row/column counters and bank pointers to 0, the token-pending state and err.
REQ-033 During reset and the cycle it is applied, outputs SHALL be b_v = 0, b_e = 0, b_d = 0, a_b = all 1, err = 0.
REQ-034 Bank storage SHALL NOT be reset.
REQ-035 Reset mid-matrix SHALL drop all buffered data and the pending token with no output.

Structure
REQ-036 Package tpose_pkg SHALL hold the bank-state enumerated type (EMPTY/FILLING/FULL) and the default N and W constants.
REQ-037 Sub-module tpose_bank SHALL hold one N x N x W register array with a row-write port and a column/row-select read port; tpose_pp SHALL instantiate it twice.

Verification
REQ-038 N=8, W=16, mode=0, feed M[r][k] = 16*r + k, b_b=0 -> columns out with b channel k at column c = 16*k + c; first b_v the cycle after row 7.
REQ-039 Three back-to-back matrices, mode=0 then 1 then 0, no stalls -> 24 consecutive output fires, rows passed unchanged for matrix 2, a_b never high.
REQ-040 b_b[3] held high for 20 cycles mid-drain -> b_d frozen; a_b rises after the second bank fills; no data lost or duplicated.
REQ-041 Token (a_e all 1) after row 3 of a matrix -> err = 1, no output from the partial matrix, then one b_e vector with b_d = 0.
REQ-042 Token right after a full matrix -> 8 data vectors then the b_e vector; a_b high from the token until the b_e fire.
REQ-043 Reset asserted at row 5 of matrix 2 -> b_v = 0 the next cycle, and a fresh matrix afterwards transposes correctly.

Source files
------------

// File: rtl/tpose_pkg.sv
// Shared types and default sizing for the ping-pong transpose block.
package tpose_pkg;

  localparam int DEF_N = 8;
  localparam int DEF_W = 16;

  // Life cycle of one storage bank.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

endpackage

// File: rtl/tpose_bank.sv
// One N x N word bank: row-wide write port, combinational read of either a
// column (transpose) or a row (pass-through) selected by rd_idx.
module tpose_bank
  import tpose_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic                 clock,
  input  logic                 wr_en,
  input  logic [$clog2(N)-1:0] wr_row,
  input  logic [N*W-1:0]       wr_data,
  input  logic [$clog2(N)-1:0] rd_idx,
  input  logic                 rd_transpose,
  output logic [N*W-1:0]       rd_data
);

  logic [W-1:0] mem [N][N];

  // Row write: channel k of the input vector lands in column k.
  // NOTE: storage has no reset; the bank state machine in the parent decides
  // when contents are meaningful, so clearing the array would only cost logic.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int k = 0; k < N; k++) begin
        mem[wr_row][k] <= wr_data[k*W +: W];
      end
    end
  end

  // Read mux: column rd_idx in transpose mode, row rd_idx in pass-through.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N; k++) begin
      rd_data[k*W +: W] = rd_transpose ? mem[k][rd_idx] : mem[rd_idx][k];
    end
  end

endmodule

// File: rtl/tpose_pp.sv
// Ping-pong N x N matrix transposer with row pass-through mode, end-of-stream
// token handling and a sticky error for streams that end mid-matrix.
module tpose_pp
  import tpose_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N*W-1:0] a_d,
  input  logic [N-1:0]   a_e,
  input  logic [N-1:0]   a_v,
  output logic [N-1:0]   a_b,
  output logic [N*W-1:0] b_d,
  output logic [N-1:0]   b_e,
  output logic [N-1:0]   b_v,
  input  logic [N-1:0]   b_b,
  input  logic           mode,
  output logic           err
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  bank_state_t   bank_state [2];
  logic [1:0]    bank_mode;     // 1 = pass-through, captured on row 0
  logic          fill_ptr;
  logic          drain_ptr;
  logic [CW-1:0] row_cnt;
  logic [CW-1:0] col_cnt;
  logic          tok_pend;

  logic [N*W-1:0] rd_data [2];
  logic fill_full, drain_full, tok_ready;
  logic in_fire, out_fire, is_token, wr_en;

  // Handshake decode; a token may only leave once no FULL bank remains.
  always_comb begin
    fill_full  = (bank_state[fill_ptr] == FULL);
    drain_full = (bank_state[drain_ptr] == FULL);
    tok_ready  = tok_pend && (bank_state[0] != FULL) && (bank_state[1] != FULL);
    in_fire    = (&a_v) & ~a_b[0];
    out_fire   = b_v[0] & ~(|b_b);
    is_token   = &a_e;
    wr_en      = in_fire & ~is_token;
  end

  tpose_bank #(.N(N), .W(W)) u_bank0 (
    .clock        (clock),
    .wr_en        (wr_en && (fill_ptr == 1'b0)),
    .wr_row       (row_cnt),
    .wr_data      (a_d),
    .rd_idx       (col_cnt),
    .rd_transpose (~bank_mode[0]),
    .rd_data      (rd_data[0])
  );

  tpose_bank #(.N(N), .W(W)) u_bank1 (
    .clock        (clock),
    .wr_en        (wr_en && (fill_ptr == 1'b1)),
    .wr_row       (row_cnt),
    .wr_data      (a_d),
    .rd_idx       (col_cnt),
    .rd_transpose (~bank_mode[1]),
    .rd_data      (rd_data[1])
  );

  // Output drive; reset forces the idle/blocked pattern immediately.
  always_comb begin
    a_b = {N{reset | fill_full | tok_pend}};
    b_v = {N{~reset & (drain_full | tok_ready)}};
    b_e = {N{~reset & ~drain_full & tok_ready}};
    b_d = (~reset & drain_full) ? rd_data[drain_ptr] : '0;
  end

  // Bank state, pointers, counters, token and error bookkeeping.
  // NOTE: all state here uses non-blocking assignments so every update in a
  // cycle sees the pre-edge values, letting fill and drain complete together.
  always_ff @(posedge clock) begin
    if (reset) begin
      bank_state[0] <= EMPTY;
      bank_state[1] <= EMPTY;
      bank_mode     <= '0;
      fill_ptr      <= 1'b0;
      drain_ptr     <= 1'b0;
      row_cnt       <= '0;
      col_cnt       <= '0;
      tok_pend      <= 1'b0;
      err           <= 1'b0;
    end else begin
      if (wr_en) begin
        if (row_cnt == '0) begin
          bank_mode[fill_ptr]  <= mode;
          bank_state[fill_ptr] <= FILLING;
        end
        if (row_cnt == LAST) begin
          bank_state[fill_ptr] <= FULL;
          fill_ptr             <= ~fill_ptr;
          row_cnt              <= '0;
        end else begin
          row_cnt <= row_cnt + CW'(1);
        end
      end

      if (in_fire && is_token) begin
        tok_pend <= 1'b1;
        row_cnt  <= '0;
        if (bank_state[fill_ptr] == FILLING) begin
          bank_state[fill_ptr] <= EMPTY;
          err                  <= 1'b1;
        end
      end

      // The drain bank is FULL here, so it never aliases the fill bank above.
      if (out_fire) begin
        if (drain_full) begin
          if (col_cnt == LAST) begin
            bank_state[drain_ptr] <= EMPTY;
            drain_ptr             <= ~drain_ptr;
            col_cnt               <= '0;
          end else begin
            col_cnt <= col_cnt + CW'(1);
          end
        end else begin
          tok_pend <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tpose_pp.sv
// Directed bench for tpose_pp: cycle-exact table for a first matrix, then
// stream sequences checked against a transaction-level expected queue.
module tb_tpose_pp;

  localparam int N = 8;
  localparam int W = 16;

  typedef logic [N*W-1:0] vec_t;

  typedef struct {
    logic [N-1:0] a_v;
    vec_t         a_d;
    logic [N-1:0] b_b;
    logic         exp_b_v;
    logic [N-1:0] exp_a_b;
    vec_t         exp_b_d;
  } tv_t;

  typedef struct {
    bit           eos;
    bit           md;
    vec_t         d;
    logic [N-1:0] e;
  } item_t;

  typedef struct {
    bit   eos;
    vec_t d;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic [N*W-1:0] a_d;
  logic [N-1:0] a_e, a_v, a_b, b_e, b_v, b_b;
  logic [N*W-1:0] b_d;
  logic         mode;
  logic         err;

  int n_checks = 0;
  int n_err    = 0;

  item_t items[$];
  exp_t  exp_q[$];
  int    fires, first_fire, last_fire;
  bit    saw_ab;

  tpose_pp #(.N(N), .W(W)) dut (
    .clock (clock),
    .reset (reset),
    .a_d   (a_d),
    .a_e   (a_e),
    .a_v   (a_v),
    .a_b   (a_b),
    .b_d   (b_d),
    .b_e   (b_e),
    .b_v   (b_v),
    .b_b   (b_b),
    .mode  (mode),
    .err   (err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input vec_t act, input vec_t exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Matrix m, row r, channel k holds m*256 + 16*r + k.
  function automatic vec_t mat_row(input int m, input int r);
    vec_t v;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(m*256 + 16*r + k);
    return v;
  endfunction

  // Output vector c: transpose gives M[k][c], pass-through gives M[c][k].
  function automatic vec_t mat_out(input int m, input int c, input bit pass);
    vec_t v;
    for (int k = 0; k < N; k++)
      v[k*W +: W] = pass ? W'(m*256 + 16*c + k) : W'(m*256 + 16*k + c);
    return v;
  endfunction

  task automatic push_rows(input int m, input bit md, input int rows, input bit mixed);
    item_t it;
    for (int r = 0; r < rows; r++) begin
      it.eos = 1'b0;
      it.md  = md;
      it.d   = mat_row(m, r);
      it.e   = (mixed && r == 2) ? 8'h0F : 8'h00;
      items.push_back(it);
    end
  endtask

  task automatic push_matrix(input int m, input bit md, input bit mixed);
    exp_t ex;
    push_rows(m, md, N, mixed);
    for (int c = 0; c < N; c++) begin
      ex.eos = 1'b0;
      ex.d   = mat_out(m, c, md);
      exp_q.push_back(ex);
    end
  endtask

  task automatic push_token();
    item_t it;
    exp_t  ex;
    it.eos = 1'b1;
    it.md  = 1'b0;
    it.d   = {4{32'hDEADBEEF}};
    it.e   = '1;
    items.push_back(it);
    ex.eos = 1'b1;
    ex.d   = '0;
    exp_q.push_back(ex);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    a_v = '0; a_e = '0; a_d = '0; b_b = '0; mode = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    items.delete();
    exp_q.delete();
  endtask

  // Offer queued items every cycle, compare every output fire against exp_q.
  task automatic run_stream(input int stall_start, input int stall_len);
    int   cyc = 0;
    int   idx = 0;
    bit   prev_stalled = 0;
    bit   tok_wait = 0;
    vec_t prev_d;
    logic [N-1:0] prev_v, prev_e;
    bit   in_fire, out_fire;
    exp_t ex;
    fires = 0; first_fire = -1; last_fire = -1; saw_ab = 0;
    while ((idx < items.size() || exp_q.size() > 0) && cyc < 600) begin
      @(negedge clock);
      if (idx < items.size()) begin
        a_v  = '1;
        a_d  = items[idx].d;
        a_e  = items[idx].eos ? '1 : items[idx].e;
        mode = items[idx].md;
      end else begin
        a_v = '0; a_e = '0; a_d = '0;
      end
      b_b = (cyc >= stall_start && cyc < stall_start + stall_len) ? 8'h08 : 8'h00;
      #1;
      if (prev_stalled) begin
        check("stall_hold_d", b_d, prev_d);
        check("stall_hold_v", N*W'(b_v), N*W'(prev_v));
        check("stall_hold_e", N*W'(b_e), N*W'(prev_e));
      end
      if (tok_wait) check("ab_during_token", N*W'(a_b), N*W'({N{1'b1}}));
      in_fire  = (&a_v) & ~a_b[0];
      out_fire = b_v[0] & ~(|b_b);
      if (out_fire) begin
        if (exp_q.size() == 0) begin
          check("extra_output", N*W'(1), N*W'(0));
        end else begin
          ex = exp_q.pop_front();
          check("out_eos", N*W'(b_e), ex.eos ? N*W'({N{1'b1}}) : '0);
          check("out_data", b_d, ex.d);
          if (ex.eos) tok_wait = 0;
        end
        if (first_fire < 0) first_fire = cyc;
        last_fire = cyc;
        fires++;
      end
      prev_stalled = b_v[0] & (|b_b);
      prev_d = b_d; prev_v = b_v; prev_e = b_e;
      if (a_b[0]) saw_ab = 1;
      if (in_fire) begin
        if (items[idx].eos) tok_wait = 1;
        idx++;
      end
      cyc++;
    end
    check("stream_drained", N*W'(exp_q.size() == 0 && idx == items.size()), N*W'(1));
    @(negedge clock);
    a_v = '0; a_e = '0; a_d = '0; b_b = '0;
  endtask

  tv_t tv[$];

  initial begin
    tv_t t;
    reset = 1'b1;
    a_v = '0; a_e = '0; a_d = '0; b_b = '0; mode = 1'b0;

    // Reset state, including while reset is held.
    repeat (2) @(negedge clock);
    #1;
    check("rst_b_v", N*W'(b_v), '0);
    check("rst_b_e", N*W'(b_e), '0);
    check("rst_b_d", b_d, '0);
    check("rst_a_b", N*W'(a_b), N*W'({N{1'b1}}));
    check("rst_err", N*W'(err), '0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_rst_a_b", N*W'(a_b), '0);
    check("post_rst_b_v", N*W'(b_v), '0);

    // Cycle-exact first matrix: 8 rows, 1-cycle stall on column 0, 8 columns.
    for (int r = 0; r < N; r++) begin
      t.a_v = '1; t.a_d = mat_row(0, r); t.b_b = '0;
      t.exp_b_v = 1'b0; t.exp_a_b = '0; t.exp_b_d = '0;
      tv.push_back(t);
    end
    t.a_v = '0; t.a_d = '0; t.b_b = 8'h01;
    t.exp_b_v = 1'b1; t.exp_a_b = '0; t.exp_b_d = mat_out(0, 0, 1'b0);
    tv.push_back(t);
    for (int c = 0; c < N; c++) begin
      t.a_v = '0; t.a_d = '0; t.b_b = '0;
      t.exp_b_v = 1'b1; t.exp_a_b = '0; t.exp_b_d = mat_out(0, c, 1'b0);
      tv.push_back(t);
    end
    t.a_v = '0; t.a_d = '0; t.b_b = '0;
    t.exp_b_v = 1'b0; t.exp_a_b = '0; t.exp_b_d = '0;
    tv.push_back(t);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clock);
      a_v = tv[i].a_v; a_d = tv[i].a_d; b_b = tv[i].b_b; a_e = '0; mode = 1'b0;
      #1;
      check($sformatf("tv%0d_b_v", i), N*W'(b_v), tv[i].exp_b_v ? N*W'({N{1'b1}}) : '0);
      check($sformatf("tv%0d_a_b", i), N*W'(a_b), N*W'(tv[i].exp_a_b));
      check($sformatf("tv%0d_b_e", i), N*W'(b_e), '0);
      if (tv[i].exp_b_v) check($sformatf("tv%0d_b_d", i), b_d, tv[i].exp_b_d);
    end

    // Three back-to-back matrices, modes 0/1/0, mixed a_e treated as data.
    do_reset();
    push_matrix(1, 1'b0, 1'b0);
    push_matrix(2, 1'b1, 1'b1);
    push_matrix(3, 1'b0, 1'b0);
    run_stream(1000, 0);
    check("b2b_fires", N*W'(fires), N*W'(24));
    check("b2b_first", N*W'(first_fire), N*W'(8));
    check("b2b_contig", N*W'(last_fire - first_fire), N*W'(23));
    check("b2b_no_ab", N*W'(saw_ab), '0);

    // Consumer stall of 20 cycles mid-drain.
    do_reset();
    push_matrix(4, 1'b0, 1'b0);
    push_matrix(5, 1'b0, 1'b0);
    push_matrix(6, 1'b1, 1'b0);
    run_stream(10, 20);
    check("stall_fires", N*W'(fires), N*W'(24));
    check("stall_saw_ab", N*W'(saw_ab), N*W'(1));

    // Token after row 3: partial matrix dropped, err set, one b_e vector.
    do_reset();
    push_rows(7, 1'b0, 4, 1'b0);
    push_token();
    run_stream(1000, 0);
    check("partial_fires", N*W'(fires), N*W'(1));
    check("partial_err", N*W'(err), N*W'(1));

    // Token right after a full matrix: 8 data vectors then b_e, no err.
    do_reset();
    check("err_cleared", N*W'(err), '0);
    push_matrix(8, 1'b0, 1'b0);
    push_token();
    run_stream(1000, 0);
    check("full_tok_fires", N*W'(fires), N*W'(9));
    check("full_tok_err", N*W'(err), '0);

    // Reset at row 5 of the second matrix while output is stalled.
    do_reset();
    for (int i = 0; i < N + 5; i++) begin
      @(negedge clock);
      a_v = '1; a_e = '0; b_b = '1; mode = 1'b0;
      a_d = (i < N) ? mat_row(9, i) : mat_row(10, i - N);
    end
    @(negedge clock);
    a_v = '0;
    #1;
    check("pre_rst_b_v", N*W'(b_v), N*W'({N{1'b1}}));
    @(negedge clock);
    reset = 1'b1;
    a_v = '1; a_d = mat_row(10, 5);
    #1;
    check("mid_rst_b_v", N*W'(b_v), '0);
    check("mid_rst_b_e", N*W'(b_e), '0);
    check("mid_rst_b_d", b_d, '0);
    check("mid_rst_a_b", N*W'(a_b), N*W'({N{1'b1}}));
    @(negedge clock);
    reset = 1'b0;
    a_v = '0; a_d = '0; b_b = '0;
    #1;
    check("after_rst_b_v", N*W'(b_v), '0);
    check("after_rst_a_b", N*W'(a_b), '0);
    items.delete();
    exp_q.delete();
    push_matrix(11, 1'b0, 1'b0);
    run_stream(1000, 0);
    check("after_rst_fires", N*W'(fires), N*W'(8));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
